uart_rx_8n1: RTL



---
 rtl/uart_rx_8n1.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 UART receiver with one-byte buffer; UART_RX_MAJORITY_EN selects 2-of-3 majority sampling
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rxack,
    output logic [7:0] rxbyte,
    output logic       rxvalid,
    output logic       rxbusy,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    // Decision taken one cycle after the nominal centre; later bits follow from the cnt reset.
    localparam logic [15:0] START_PT = 16'(CLKS_PER_BIT / 2);
`else
    localparam logic [15:0] START_PT = 16'(CLKS_PER_BIT / 2 - 1);
`endif

    logic [2:0]  state;
    logic [15:0] cnt;
    logic [2:0]  bitidx;
    logic [7:0]  shreg;
    logic        rx_meta;
    logic        rxs;
    logic        rxs_d;
    logic        samp;

`ifdef UART_RX_MAJORITY_EN
    logic        rxs_d2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxs_d2 <= 1'b1;
        end else begin
            rxs_d2 <= rxs_d;
        end
    end

    assign samp = (rxs_d2 & rxs_d) | (rxs_d2 & rxs) | (rxs_d & rxs);
`else
    assign samp = rxs;
`endif

    assign rxbusy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            rxs_d     <= 1'b1;
            state     <= S_IDLE;
            cnt       <= 16'd0;
            bitidx    <= 3'd0;
            shreg     <= 8'h00;
            rxbyte    <= 8'h00;
            rxvalid   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rxs       <= rx_meta;
            rxs_d     <= rxs;
            frame_err <= 1'b0;

            // A good stop in the same cycle overrides this clear below.
            if (rxack && rxvalid) begin
                rxvalid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (rxs_d && !rxs) begin
                        cnt   <= 16'd0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == START_PT) begin
                        if (!samp) begin
                            state  <= S_DATA;
                            cnt    <= 16'd0;
                            bitidx <= 3'd0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_END) begin
                        shreg[bitidx] <= samp;
                        cnt           <= 16'd0;
                        bitidx        <= bitidx + 3'd1;
                        if (bitidx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_END) begin
                        if (samp) begin
                            if (!rxvalid || rxack) begin
                                rxbyte  <= shreg;
                                rxvalid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
